stopwatch_button_ctrl: RTL and testbench



---
 rtl/stopwatch_button_ctrl_pkg.sv | 10 +
 rtl/stopwatch_button_ctrl_button_debounce.sv | 40 ++++
 rtl/stopwatch_button_ctrl.sv | 66 ++++++
 tb/tb_stopwatch_button_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/stopwatch_button_ctrl_pkg.sv
// stopwatch_button_ctrl_pkg: shared state encodings and debounce constants
package stopwatch_button_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2
    } state_t;
    localparam int DB_CYCLES_DEFAULT = 1000000;
    localparam int DB_CYCLES_SIM     = 8;
endpackage

// File: rtl/stopwatch_button_ctrl_button_debounce.sv
// button_debounce: 2-FF synchroniser, stability counter and one-cycle press pulse
module button_debounce #(
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 20
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);
    logic [1:0]       sync_q;
    logic             level_q, level_d, dly_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // count mismatched cycles; the level flips only after DB_CYCLES in a row
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_W'(DB_CYCLES - 1)) level_d = ~level_q;
            else cnt_d = cnt_q + 1'b1;
        end
    end
    // synchroniser, debounced level and its one-cycle delay for edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            dly_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            level_q <= level_d;
            dly_q   <= level_q;
            cnt_q   <= cnt_d;
        end
    end
    assign level = level_q;
    assign press = level_q & ~dly_q;
endmodule

// File: rtl/stopwatch_button_ctrl.sv
// stopwatch_button_ctrl: debounced start/stop and clear buttons driving the run/clear FSM
module stopwatch_button_ctrl
    import stopwatch_button_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNT_W     = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    output logic       run,
    output logic       clear_pulse,
    output logic [1:0] state
);
    logic       ss_press, clr_press;
    logic [1:0] unused_level;
    state_t     state_q, state_d;
    logic       run_q, clear_q, clear_d;

    button_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_ss (
        .clock(clock), .reset(reset), .raw(btn_start_stop),
        .level(unused_level[0]), .press(ss_press)
    );
    button_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_clr (
        .clock(clock), .reset(reset), .raw(btn_clear),
        .level(unused_level[1]), .press(clr_press)
    );

    // clear is honoured only when not counting; start/stop wins while running
    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr_press) clear_d = 1'b1;
                else if (ss_press) state_d = ST_RUNNING;
            end
            ST_RUNNING: if (ss_press) state_d = ST_PAUSED;
            ST_PAUSED: begin
                if (clr_press) begin
                    state_d = ST_IDLE;
                    clear_d = 1'b1;
                end else if (ss_press) state_d = ST_RUNNING;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= (state_d == ST_RUNNING);
            clear_q <= clear_d;
        end
    end

    assign state       = state_q;
    assign run         = run_q;
    assign clear_pulse = clear_q;
endmodule

// File: tb/tb_stopwatch_button_ctrl.sv
// tb_stopwatch_button_ctrl: directed scenario tests with hand-computed timing (DB_CYCLES=8)
module tb_stopwatch_button_ctrl;
    import stopwatch_button_ctrl_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       btn_start_stop = 1'b0;
    logic       btn_clear = 1'b0;
    logic       run, clear_pulse;
    logic [1:0] state;
    int checks = 0;
    int failures = 0;
    int pulses = 0;
    int run_ones = 0;

    stopwatch_button_ctrl #(.DB_CYCLES(DB_CYCLES_SIM), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .btn_start_stop(btn_start_stop),
        .btn_clear(btn_clear), .run(run), .clear_pulse(clear_pulse), .state(state)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            pulses += int'(clear_pulse);
            run_ones += int'(run);
        end
    endtask

    // press a button pattern from the idle-input condition until the FSM reacts (edge 10), then release fully
    task automatic press(input logic ss, input logic clr);
        btn_start_stop = ss;
        btn_clear = clr;
        tick(11);
        btn_start_stop = 1'b0;
        btn_clear = 1'b0;
        tick(12);
    endtask

    task automatic test_reset;
        #2;
        checks++; if (run !== 1'b0) begin failures++; $display("FAIL reset_run: got %b want 0", run); end
        checks++; if (clear_pulse !== 1'b0) begin failures++; $display("FAIL reset_clear: got %b want 0", clear_pulse); end
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", state); end
        tick(2);
        reset = 1'b0;
    endtask

    task automatic test_start;
        pulses = 0;
        btn_start_stop = 1'b1;
        tick(10);
        checks++; if (run !== 1'b0) begin failures++; $display("FAIL start_early: run got %b want 0 at edge 9", run); end
        tick(1);
        checks++; if (run !== 1'b1) begin failures++; $display("FAIL start_run: got %b want 1 at edge 10", run); end
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL start_state: got %0d want 1", state); end
        btn_start_stop = 1'b0;
        tick(12);
        checks++; if (pulses !== 0) begin failures++; $display("FAIL start_no_clear: pulses got %0d want 0", pulses); end
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL start_release: state got %0d want 1", state); end
    endtask

    task automatic test_pause_clear;
        press(1'b1, 1'b0);
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL pause_state: got %0d want 2", state); end
        checks++; if (run !== 1'b0) begin failures++; $display("FAIL pause_run: got %b want 0", run); end
        pulses = 0;
        btn_clear = 1'b1;
        tick(10);
        checks++; if (clear_pulse !== 1'b0) begin failures++; $display("FAIL clear_early: got %b want 0 at edge 9", clear_pulse); end
        tick(1);
        checks++; if (clear_pulse !== 1'b1) begin failures++; $display("FAIL clear_pulse: got %b want 1 at edge 10", clear_pulse); end
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL clear_state: got %0d want 0", state); end
        tick(1);
        checks++; if (clear_pulse !== 1'b0) begin failures++; $display("FAIL clear_width: got %b want 0 at edge 11", clear_pulse); end
        tick(30);
        btn_clear = 1'b0;
        tick(12);
        checks++; if (pulses !== 1) begin failures++; $display("FAIL clear_once: pulses got %0d want 1", pulses); end
    endtask

    task automatic test_bounce;
        run_ones = 0;
        for (int k = 0; k < 4; k++) begin
            btn_start_stop = ~k[0];
            tick(3);
        end
        btn_start_stop = 1'b1;
        tick(10);
        checks++; if (run_ones !== 0) begin failures++; $display("FAIL bounce_quiet: run high cycles got %0d want 0", run_ones); end
        tick(1);
        checks++; if (run !== 1'b1) begin failures++; $display("FAIL bounce_run: got %b want 1", run); end
        btn_start_stop = 1'b0;
        tick(12);
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL bounce_state: got %0d want 1", state); end
    endtask

    task automatic test_clear_ignored;
        pulses = 0;
        run_ones = 0;
        btn_clear = 1'b1;
        tick(50);
        btn_clear = 1'b0;
        tick(12);
        checks++; if (pulses !== 0) begin failures++; $display("FAIL run_clear_pulse: got %0d want 0", pulses); end
        checks++; if (run_ones !== 62) begin failures++; $display("FAIL run_clear_run: run cycles got %0d want 62", run_ones); end
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL run_clear_state: got %0d want 1", state); end
    endtask

    task automatic test_simultaneous;
        pulses = 0;
        press(1'b1, 1'b1);
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL both_running: state got %0d want 2", state); end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL both_running_pulse: got %0d want 0", pulses); end
        press(1'b1, 1'b1);
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL both_paused: state got %0d want 0", state); end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL both_paused_pulse: got %0d want 1", pulses); end
        pulses = 0;
        run_ones = 0;
        press(1'b1, 1'b1);
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL both_idle: state got %0d want 0", state); end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL both_idle_pulse: got %0d want 1", pulses); end
        checks++; if (run_ones !== 0) begin failures++; $display("FAIL both_idle_run: run cycles got %0d want 0", run_ones); end
    endtask

    task automatic test_reset_mid;
        btn_clear = 1'b1;
        tick(11);
        checks++; if (clear_pulse !== 1'b1) begin failures++; $display("FAIL mid_pulse_pre: got %b want 1", clear_pulse); end
        #2 reset = 1'b1;
        #1;
        checks++; if (clear_pulse !== 1'b0) begin failures++; $display("FAIL mid_pulse_reset: got %b want 0", clear_pulse); end
        btn_clear = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(2);
        press(1'b1, 1'b0);
        checks++; if (run !== 1'b1) begin failures++; $display("FAIL mid_rerun: got %b want 1", run); end
        btn_start_stop = 1'b1;
        tick(5);
        #2 reset = 1'b1;
        #1;
        checks++; if (run !== 1'b0 || state !== 2'd0) begin failures++; $display("FAIL mid_db_reset: run %b state %0d want 0 0", run, state); end
        tick(3);
        reset = 1'b0;
        run_ones = 0;
        tick(10);
        checks++; if (run_ones !== 0) begin failures++; $display("FAIL held_early: run cycles got %0d want 0", run_ones); end
        tick(1);
        checks++; if (run !== 1'b1 || state !== 2'd1) begin failures++; $display("FAIL held_press: run %b state %0d want 1 1", run, state); end
        btn_start_stop = 1'b0;
        tick(12);
    endtask

    initial begin
        test_reset();
        test_start();
        test_pause_clear();
        test_bounce();
        test_clear_ignored();
        test_simultaneous();
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL resume_pause: state got %0d want 2", state); end
        press(1'b0, 1'b1);
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
